// File: rtl/stateful_rw_pkg.sv
// Shared types for the stateful read-modify-write atom.
// Opcode enum and the S1/S2/S3 pipeline bundle.
package atom_pkg;

  localparam int COUNT_WIDTH = 32;
  localparam int IDX_MAX = 16;

  typedef enum logic [3:0] {
    OP_READ  = 4'd0,
    OP_SET   = 4'd1,
    OP_ADD   = 4'd2,
    OP_ADDC  = 4'd3,
    OP_SUB   = 4'd4,
    OP_CSET  = 4'd5,
    OP_MAX   = 4'd6,
    OP_CLEAR = 4'd7
  } op_e;

  typedef struct packed {
    logic                   valid;
    logic [IDX_MAX-1:0]     index;
    logic [COUNT_WIDTH-1:0] pkt_1;
    logic [COUNT_WIDTH-1:0] pkt_2;
    logic [COUNT_WIDTH-1:0] cons_1;
    op_e                    opcode;
  } pipe_t;

endpackage

// File: rtl/stateful_rw_if.sv
// Packet-in / result-out bundle of the stateful atom.
// master drives packets, slave is the atom.
interface stateful_rw_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int IDX_WIDTH   = 4
);

  logic                   i_valid;
  logic [IDX_WIDTH-1:0]   i_index;
  logic [COUNT_WIDTH-1:0] pkt_1;
  logic [COUNT_WIDTH-1:0] pkt_2;
  logic [COUNT_WIDTH-1:0] cons_1;
  logic [3:0]             opcode;
  logic                   o_valid;
  logic [COUNT_WIDTH-1:0] o_read;
  logic [COUNT_WIDTH-1:0] o_write;

  modport master (
    output i_valid, i_index, pkt_1,
    output pkt_2, cons_1, opcode,
    input  o_valid, o_read, o_write
  );

  modport slave (
    input  i_valid, i_index, pkt_1,
    input  pkt_2, cons_1, opcode,
    output o_valid, o_read, o_write
  );

endinterface

// File: rtl/stateful_rw_alu.sv
// Combinational update function of the stateful atom.
// STATEFUL_SATURATE_EN clamps opcodes 2/3/4 instead of wrapping.
module stateful_alu
  import atom_pkg::*;
#(
  parameter int CW = atom_pkg::COUNT_WIDTH
) (
  input  logic [CW-1:0] s,
  input  logic [CW-1:0] pkt_1,
  input  logic [CW-1:0] pkt_2,
  input  logic [CW-1:0] cons_1,
  input  op_e           opcode,
  output logic [CW-1:0] new_val
);

  logic [CW-1:0] r_add;
  logic [CW-1:0] r_addc;
  logic [CW-1:0] r_sub;

`ifdef STATEFUL_SATURATE_EN
  logic [CW:0] add_p;
  logic [CW:0] add_c;

  assign add_p  = {1'b0, s} + {1'b0, pkt_1};
  assign add_c  = {1'b0, s} + {1'b0, cons_1};
  assign r_add  = add_p[CW] ? '1 : add_p[CW-1:0];
  assign r_addc = add_c[CW] ? '1 : add_c[CW-1:0];
  assign r_sub  = (s < pkt_1) ? '0 : s - pkt_1;
`else
  assign r_add  = s + pkt_1;
  assign r_addc = s + cons_1;
  assign r_sub  = s - pkt_1;
`endif

  always_comb begin
    new_val = s;
    unique case (opcode)
      OP_SET:   new_val = pkt_1;
      OP_ADD:   new_val = r_add;
      OP_ADDC:  new_val = r_addc;
      OP_SUB:   new_val = r_sub;
      OP_CSET:  new_val = (pkt_1 != '0) ? pkt_2 : s;
      OP_MAX:   new_val = (s > pkt_1) ? s : pkt_1;
      OP_CLEAR: new_val = '0;
      default:  new_val = s;
    endcase
  end

endmodule

// File: rtl/stateful_rw.sv
// Stateful read-modify-write atom: 3-stage pipeline with forwarding.
// Optional saturation via STATEFUL_SATURATE_EN (see stateful_alu).
module stateful_rw
  import atom_pkg::*;
#(
  parameter int COUNT_WIDTH = atom_pkg::COUNT_WIDTH,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input logic         clk,
  input logic         rst,
  stateful_rw_if.slave bus
);

  localparam logic [IDX_MAX-1:0] LIM = IDX_MAX'(NUM_ENTRIES);

  logic [COUNT_WIDTH-1:0] mem [NUM_ENTRIES];

  pipe_t s1, s2, s3, s1_d;
  logic [COUNT_WIDTH-1:0] s2_rd, s3_rd;
  logic [COUNT_WIDTH-1:0] s2_rd_d, s3_rd_d;
  logic [COUNT_WIDTH-1:0] mem_rd, new_val;
  logic s1_inr, s3_inr, s3_wr;

  always_comb begin
    s1_d        = '0;
    s1_d.valid  = bus.i_valid;
    s1_d.index  = IDX_MAX'(bus.i_index);
    s1_d.pkt_1  = bus.pkt_1;
    s1_d.pkt_2  = bus.pkt_2;
    s1_d.cons_1 = bus.cons_1;
    s1_d.opcode = op_e'(bus.opcode);
  end

  assign s1_inr = s1.index < LIM;
  assign s3_inr = s3.index < LIM;
  assign s3_wr  = s3.valid && s3_inr;

  assign mem_rd = s1_inr ? mem[s1.index[IDX_WIDTH-1:0]] : '0;

  // S3's result bypasses the array for both younger packets
  assign s2_rd_d = (s3_wr && s1.index == s3.index)
                 ? new_val : mem_rd;
  assign s3_rd_d = (s3_wr && s2.index == s3.index)
                 ? new_val : s2_rd;

  stateful_alu #(.CW(COUNT_WIDTH)) u_alu (
    .s       (s3_rd),
    .pkt_1   (s3.pkt_1),
    .pkt_2   (s3.pkt_2),
    .cons_1  (s3.cons_1),
    .opcode  (s3.opcode),
    .new_val (new_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      s2_rd       <= '0;
      s3_rd       <= '0;
      bus.o_valid <= 1'b0;
      bus.o_read  <= '0;
      bus.o_write <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
        mem[i] <= '0;
    end else begin
      s1          <= s1_d;
      s2          <= s1;
      s2_rd       <= s2_rd_d;
      s3          <= s2;
      s3_rd       <= s3_rd_d;
      bus.o_valid <= s3.valid;
      if (s3.valid) begin
        bus.o_read  <= s3_inr ? s3_rd : '0;
        bus.o_write <= s3_inr ? new_val : '0;
      end
      if (s3_wr)
        mem[s3.index[IDX_WIDTH-1:0]] <= new_val;
    end
  end

endmodule

// File: tb/tb_stateful_rw.sv
// Randomized bench for stateful_rw against a sequential array model.
// Honors STATEFUL_SATURATE_EN in the model when defined.
module tb_stateful_rw;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stateful_rw_if #(.COUNT_WIDTH(32), .IDX_WIDTH(4)) bus();

  stateful_rw #(.COUNT_WIDTH(32), .NUM_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;

  bit [31:0] ref_mem [16];
  bit        hv [4];
  bit [31:0] hr [4];
  bit [31:0] hw [4];
  bit [31:0] last_r, last_w;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %h exp %h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] upd(bit [31:0] s, bit [31:0] p1,
      bit [31:0] p2, bit [31:0] c, bit [3:0] op);
    longint unsigned t;
    case (op)
      4'd1: return p1;
      4'd2, 4'd3: begin
        t = s;
        t += (op == 4'd2) ? p1 : c;
`ifdef STATEFUL_SATURATE_EN
        if (t > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return t[31:0];
      end
      4'd4: begin
`ifdef STATEFUL_SATURATE_EN
        if (p1 > s) return 32'd0;
`endif
        return s - p1;
      end
      4'd5: return (p1 != 0) ? p2 : s;
      4'd6: return (s > p1) ? s : p1;
      4'd7: return 32'd0;
      default: return s;
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 16; k++) ref_mem[k] = 0;
    for (int k = 0; k < 4; k++) begin
      hv[k] = 0; hr[k] = 0; hw[k] = 0;
    end
    last_r = 0;
    last_w = 0;
  endtask

  task automatic step(bit v, int idx, bit [31:0] p1,
      bit [31:0] p2, bit [31:0] c, bit [3:0] op);
    bit [31:0] s, n;
    bit [3:0]  ix;
    ix = idx[3:0];
    s = 0;
    n = 0;
    bus.i_valid = v;
    bus.i_index = ix;
    bus.pkt_1   = p1;
    bus.pkt_2   = p2;
    bus.cons_1  = c;
    bus.opcode  = op;
    if (v) begin
      s = ref_mem[ix];
      n = upd(s, p1, p2, c, op);
      ref_mem[ix] = n;
    end
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) begin
      hv[k] = hv[k-1]; hr[k] = hr[k-1]; hw[k] = hw[k-1];
    end
    hv[0] = v; hr[0] = s; hw[0] = n;
    if (hv[3]) begin
      last_r = hr[3];
      last_w = hw[3];
    end
    chk("o_valid", {31'd0, bus.o_valid}, {31'd0, hv[3]});
    chk("o_read", bus.o_read, last_r);
    chk("o_write", bus.o_write, last_w);
  endtask

  task automatic bubbles(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_read", bus.o_read, 32'd0);
    chk("rst_write", bus.o_write, 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit v;
    int idx;
    bit [31:0] p1, p2, c;
    bit [3:0]  op;
    bus.i_valid = 0; bus.i_index = 0; bus.pkt_1 = 0;
    bus.pkt_2 = 0; bus.cons_1 = 0; bus.opcode = 0;
    clear_model();
    @(posedge clk);
    #1;
    do_reset();

    // basic set then read back
    step(1, 3, 32'h55, 0, 0, 1);
    bubbles(3);
    chk("basic_w", bus.o_write, 32'h55);
    chk("basic_r", bus.o_read, 32'h0);
    step(1, 3, 0, 0, 0, 0);
    bubbles(3);
    chk("basic_rd", bus.o_read, 32'h55);

    for (int k = 0; k < 4; k++) step(1, 5, 1, 0, 0, 2);
    bubbles(3);
    chk("hazard_end", bus.o_write, 32'd4);

    step(1, 0, 32'hFFFF_FFFF, 0, 0, 1);
    step(1, 0, 0, 0, 2, 3);
    bubbles(3);
`ifdef STATEFUL_SATURATE_EN
    chk("addc_sat", bus.o_write, 32'hFFFF_FFFF);
`else
    chk("addc_wrap", bus.o_write, 32'd1);
`endif
    step(1, 0, 0, 0, 0, 7);
    step(1, 0, 5, 0, 0, 4);
    bubbles(3);
`ifdef STATEFUL_SATURATE_EN
    chk("sub_sat", bus.o_write, 32'd0);
`else
    chk("sub_wrap", bus.o_write, 32'hFFFF_FFFB);
`endif

    step(1, 9, 7, 0, 0, 1);
    step(1, 9, 0, 9, 0, 5);
    step(1, 9, 1, 9, 0, 5);
    step(1, 9, 4, 0, 0, 6);
    step(1, 9, 0, 0, 0, 7);
    step(1, 9, 3, 3, 3, 12);
    bubbles(3);

    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, 0, 0, 2);
      bubbles(1);
      step(1, 2, 1, 0, 0, 2);
      bubbles(2);
    end
    bubbles(3);

    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        do_reset();
        for (int e = 0; e < 16; e++) step(1, e, 0, 0, 0, 0);
        bubbles(3);
      end
      v   = ($urandom_range(0, 3) != 0);
      idx = $urandom_range(0, 1) ? $urandom_range(0, 3)
                                 : $urandom_range(0, 15);
      p1  = $urandom_range(0, 1) ? $urandom_range(0, 3)
                                 : $urandom;
      p2  = $urandom;
      c   = $urandom_range(0, 1) ? 32'd1 : $urandom;
      op  = 4'($urandom_range(0, 15));
      step(v, idx, p1, p2, c, op);
    end
    bubbles(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/stateful_rw.md
# stateful_rw

Stateful read-modify-write atom for the packet-transaction pipeline; it is the counterpart to the stateless ALU atom that only computes write values. It holds an indexed array of state words and accepts one packet per cycle with no backpressure. For each valid packet it reads the addressed entry, applies an opcode-selected update using packet fields, and writes the result back. It emits both the pre-update value (`o_read`) and the post-update value (`o_write`) downstream.

## Interface
- `COUNT_WIDTH`, 32, width of state words and packet fields
- `NUM_ENTRIES`, 16, number of state entries
- `IDX_WIDTH`, `$clog2(NUM_ENTRIES)`, index width (derived)
- `clk`  in  1  clock; all state is updated on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_valid`  in  1  packet present this cycle
- `i_index`  in  IDX_WIDTH  state entry selected
- `pkt_1`, `pkt_2`  in  COUNT_WIDTH  packet operands
- `cons_1`  in  COUNT_WIDTH  configured constant
- `opcode`  in  4  update operation
- `o_valid`  out  1  result present
- `o_read`  out  COUNT_WIDTH  entry value before update
- `o_write`  out  COUNT_WIDTH  entry value after update

## Operation
- Three stages:
  - S1 registers the inputs.
  - S2 reads `state[index]` into a register.
  - S3 computes the new value, writes it to `state[index]`, and registers the outputs.
- Opcodes (`s` = old state):
  - 0 read only, new = `s`
  - 1 new = `pkt_1`
  - 2 new = `s + pkt_1`
  - 3 new = `s + cons_1`
  - 4 new = `s - pkt_1`
  - 5 new = `pkt_1 != 0 ? pkt_2 : s`
  - 6 new = max(`s`, `pkt_1`), unsigned
  - 7 new = 0
  - 8–15 behave as opcode 0
- Arithmetic is unsigned, modulo 2^COUNT_WIDTH; it wraps unless saturation is compiled in (see Configuration).
- `i_index >= NUM_ENTRIES` (non-power-of-2 sizes only): no write occurs, `o_read` = `o_write` = 0, and `o_valid` still asserts.
- Hazard forwarding:
  - If the packet in S2 has the same index as a valid packet in S3, the S2 read takes S3's new value, not the array value.
  - If the packet entering S2 matches the index written at that same edge, it also takes the forwarded value.
  - Net effect: back-to-back packets always observe strictly sequential semantics.
- Invalid slots (`i_valid` = 0) propagate as bubbles: no write, and `o_read`/`o_write` hold their last values.

## Timing
- Latency: a packet sampled at edge N appears on the outputs after edge N+3, with `o_valid` high for one cycle per packet.
- Throughput: one packet per cycle, sustained indefinitely.
- Reset, asynchronously and immediately:
  - all state entries = 0
  - all pipeline valids = 0
  - `o_valid` = 0, `o_read` = 0, `o_write` = 0
- Reset mid-operation discards in-flight packets; none of them produce a write.
- After `rst` deasserts, the first edge may sample a packet.
- A write to entry k at edge E is visible to an S2 read at edge E, via the forwarding path.

## Configuration
- `STATEFUL_SATURATE_EN`
  - Defined: opcodes 2 and 3 clamp at 2^COUNT_WIDTH−1, and opcode 4 clamps at 0.
  - Undefined: these opcodes wrap modulo 2^COUNT_WIDTH.
  - All other opcodes are identical in both builds.

## Structure
- Package `atom_pkg`: opcode enum (`OP_READ` … `OP_CLEAR`), `COUNT_WIDTH` default, and an S1/S2/S3 pipeline struct with fields valid, index, operands, and opcode.
- Sub-module `stateful_alu`: purely combinational update function taking (`s`, `pkt_1`, `pkt_2`, `cons_1`, `opcode`) and producing new. The saturation macro lives here only.
- Top level owns the state array, pipeline registers, and forwarding mux.

## Test plan
- Reset values: assert `rst` mid-stream → all outputs 0 immediately. A subsequent opcode 0 read of every entry returns 0.
- Basic update: idx 3, opcode 1, `pkt_1`=0x55 → after 3 edges `o_read`=0, `o_write`=0x55. A following opcode 0 read of idx 3 returns 0x55.
- Back-to-back hazard: four consecutive opcode 2 packets to idx 5 with `pkt_1`=1 → `o_write` sequence 1, 2, 3, 4 and `o_read` sequence 0, 1, 2, 3.
- Wrap vs saturation: idx 0 set to 0xFFFFFFFF, then opcode 3 with `cons_1`=2:
  - without the macro → `o_write`=1
  - with `STATEFUL_SATURATE_EN` → 0xFFFFFFFF
  - opcode 4 with `pkt_1`=5 on a 0 entry → 0xFFFFFFFB without the macro, 0 with it
- Conditional, max and clear, starting from 7:
  - opcode 5 with `pkt_1`=0, `pkt_2`=9 → stays 7
  - opcode 5 with `pkt_1`=1 → becomes 9
  - opcode 6 with `pkt_1`=4 → stays 9
  - opcode 7 → becomes 0
  - opcode 12 → read only
- Bubbles and interleaving: alternating idx 1 / idx 2 increments with `i_valid` gaps → each entry counts independently, and outputs hold their values during gaps.
